// File: rtl/ones_pkg.sv
// Shared definitions for the ones-pattern generator: default widths,
// state encoding and the count saturation helper.
package ones_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_CW    = 5;
    localparam int DEF_RW    = 4;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BUILD = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = S_IDLE,
        ST_BUILD = S_BUILD,
        ST_DONE  = S_DONE
    } state_t;

    // Clamp a requested count to the word width.
    function automatic logic [DEF_CW-1:0] sat_count(input logic [DEF_CW-1:0] count);
        return (count > DEF_CW'(DEF_WIDTH)) ? DEF_CW'(DEF_WIDTH) : count;
    endfunction

endpackage

// File: rtl/ones_pattern_gen.sv
// Builds a WIDTH-bit word holding exactly min(COUNT, WIDTH) contiguous ones,
// starting at bit ROT and wrapping modulo WIDTH. One bit is set per clock;
// the finished word is offered on a valid/ready handshake.
//
// state | meaning
// IDLE  | waiting for a request, IN_READY high
// BUILD | setting one bit per cycle at ptr, rem bits still to set
// DONE  | word complete, OUT_VALID high until the consumer takes it
module ones_pattern_gen
    import ones_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CW    = DEF_CW,
    parameter int RW    = DEF_RW
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [CW-1:0]    COUNT,
    input  logic [RW-1:0]    ROT,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] DATA,
    output logic             ERR,
    output logic             BUSY
);

    state_t           r_state;
    logic [WIDTH-1:0] r_data;
    logic [RW-1:0]    r_ptr;
    logic [CW-1:0]    r_rem;
    logic             r_err;
    logic             r_out_valid;
    logic             r_in_ready;
    logic             r_busy;

    logic             w_ovf;
    logic [CW-1:0]    w_sat;
    logic [RW-1:0]    w_ptr_next;

    // Saturate the request and compute the wrapped next bit position.
    always_comb begin
        w_ovf      = (COUNT > CW'(WIDTH));
        w_sat      = w_ovf ? CW'(WIDTH) : COUNT;
        w_ptr_next = (r_ptr == RW'(WIDTH - 1)) ? '0 : r_ptr + 1'b1;
    end

    // Sequencer: accept, fill one bit per cycle, then hold the word until taken.
    // A zero-count request goes straight to DONE; OUT_VALID is raised there one
    // cycle later so the minimum request-to-result latency is a single cycle.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state     <= ST_IDLE;
            r_data      <= '0;
            r_ptr       <= '0;
            r_rem       <= '0;
            r_err       <= 1'b0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (IN_VALID && r_in_ready) begin
                        r_data     <= '0;
                        r_ptr      <= ROT;
                        r_rem      <= w_sat;
                        r_err      <= w_ovf;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= (w_sat != '0) ? ST_BUILD : ST_DONE;
                    end
                end
                ST_BUILD: begin
                    r_data[r_ptr] <= 1'b1;
                    r_ptr         <= w_ptr_next;
                    r_rem         <= r_rem - 1'b1;
                    if (r_rem == CW'(1)) begin
                        r_state     <= ST_DONE;
                        r_out_valid <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                    end else if (OUT_READY) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign IN_READY  = r_in_ready;
    assign OUT_VALID = r_out_valid;
    assign DATA      = r_data;
    assign ERR       = r_err;
    assign BUSY      = r_busy;

endmodule

// File: tb/tb_ones_pattern_gen.sv
// Directed bench for ones_pattern_gen: a table of requests with hand-computed
// words and latencies, plus sequences for back-pressure, early OUT_READY and
// asynchronous reset during a build.
module tb_ones_pattern_gen;

    logic        CLK;
    logic        RESET;
    logic        IN_VALID;
    logic        IN_READY;
    logic [4:0]  COUNT;
    logic [3:0]  ROT;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [15:0] DATA;
    logic        ERR;
    logic        BUSY;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [4:0]  count;
        logic [3:0]  rot;
        logic [15:0] data;
        logic        err;
        int          lat;
    } vec_t;

    vec_t vecs[12];

    ones_pattern_gen dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .COUNT     (COUNT),
        .ROT       (ROT),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .DATA      (DATA),
        .ERR       (ERR),
        .BUSY      (BUSY)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    function automatic int popcnt(input logic [15:0] v);
        int n = 0;
        for (int b = 0; b < 16; b++) if (v[b]) n++;
        return n;
    endfunction

    function automatic int ref_sat(input logic [4:0] c);
        return (int'(c) > 16) ? 16 : int'(c);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Present a request mid-cycle and let the next rising edge accept it.
    task automatic send(input logic [4:0] c, input logic [3:0] r, input string name);
        COUNT    = c;
        ROT      = r;
        IN_VALID = 1'b1;
        check({name, " in_ready before accept"}, 32'(IN_READY), 32'd1);
        @(posedge CLK);
        #1;
        IN_VALID = 1'b0;
        check({name, " in_ready after accept"}, 32'(IN_READY), 32'd0);
    endtask

    // Count edges after the accept edge until OUT_VALID is seen (bounded).
    task automatic wait_valid(output int lat);
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge CLK);
            #1;
            if (OUT_VALID) begin
                lat = k;
                break;
            end
        end
    endtask

    // Complete the output handshake and confirm the block returns to idle.
    task automatic drain(input string name, input logic [15:0] exp_data);
        OUT_READY = 1'b1;
        @(posedge CLK);
        #1;
        OUT_READY = 1'b0;
        check({name, " out_valid dropped"}, 32'(OUT_VALID), 32'd0);
        check({name, " in_ready restored"}, 32'(IN_READY), 32'd1);
        check({name, " busy cleared"}, 32'(BUSY), 32'd0);
        check({name, " data kept"}, 32'(DATA), 32'(exp_data));
    endtask

    initial begin
        int lat;
        string nm;

        vecs[0]  = '{5'd5,  4'd0,  16'h001F, 1'b0, 5};
        vecs[1]  = '{5'd4,  4'd14, 16'hC003, 1'b0, 4};
        vecs[2]  = '{5'd0,  4'd7,  16'h0000, 1'b0, 1};
        vecs[3]  = '{5'd16, 4'd0,  16'hFFFF, 1'b0, 16};
        vecs[4]  = '{5'd20, 4'd3,  16'hFFFF, 1'b1, 16};
        vecs[5]  = '{5'd1,  4'd15, 16'h8000, 1'b0, 1};
        vecs[6]  = '{5'd3,  4'd15, 16'h8003, 1'b0, 3};
        vecs[7]  = '{5'd31, 4'd9,  16'hFFFF, 1'b1, 16};
        vecs[8]  = '{5'd8,  4'd4,  16'h0FF0, 1'b0, 8};
        vecs[9]  = '{5'd15, 4'd8,  16'hFF7F, 1'b0, 15};
        vecs[10] = '{5'd17, 4'd0,  16'hFFFF, 1'b1, 16};
        vecs[11] = '{5'd0,  4'd0,  16'h0000, 1'b0, 1};

        RESET     = 1'b0;
        IN_VALID  = 1'b0;
        OUT_READY = 1'b0;
        COUNT     = '0;
        ROT       = '0;
        #1 RESET  = 1'b1;
        #1;
        check("reset data",      32'(DATA),      32'd0);
        check("reset err",       32'(ERR),       32'd0);
        check("reset out_valid", 32'(OUT_VALID), 32'd0);
        check("reset busy",      32'(BUSY),      32'd0);
        check("reset in_ready",  32'(IN_READY),  32'd1);
        @(posedge CLK);
        @(posedge CLK);
        #1 RESET = 1'b0;

        // Table of requests.
        for (int i = 0; i < 12; i++) begin
            nm = $sformatf("vec%0d", i);
            send(vecs[i].count, vecs[i].rot, nm);
            wait_valid(lat);
            check({nm, " latency"},  32'(lat),  32'(vecs[i].lat));
            check({nm, " data"},     32'(DATA), 32'(vecs[i].data));
            check({nm, " err"},      32'(ERR),  32'(vecs[i].err));
            check({nm, " popcount"}, 32'(popcnt(DATA)), 32'(ref_sat(vecs[i].count)));
            check({nm, " busy"},     32'(BUSY), 32'd1);
            drain(nm, vecs[i].data);
        end

        // OUT_READY already high before a zero-count result is valid.
        OUT_READY = 1'b1;
        send(5'd0, 4'd3, "early_rdy");
        check("early_rdy valid not yet", 32'(OUT_VALID), 32'd0);
        @(posedge CLK);
        #1;
        check("early_rdy valid raised", 32'(OUT_VALID), 32'd1);
        @(posedge CLK);
        #1;
        check("early_rdy handshake", 32'(OUT_VALID), 32'd0);
        check("early_rdy in_ready",  32'(IN_READY),  32'd1);
        OUT_READY = 1'b0;

        // Back-pressure: result held for 10 cycles while a new request waits.
        send(5'd6, 4'd2, "hold");
        wait_valid(lat);
        check("hold latency", 32'(lat), 32'd6);
        COUNT    = 5'd2;
        ROT      = 4'd0;
        IN_VALID = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge CLK);
            #1;
            check("hold data stable", 32'(DATA),      32'h00FC);
            check("hold in_ready",    32'(IN_READY),  32'd0);
            check("hold out_valid",   32'(OUT_VALID), 32'd1);
        end
        OUT_READY = 1'b1;
        @(posedge CLK);
        #1;
        OUT_READY = 1'b0;
        check("hold handshake valid", 32'(OUT_VALID), 32'd0);
        check("hold handshake ready", 32'(IN_READY),  32'd1);
        @(posedge CLK);
        #1;
        IN_VALID = 1'b0;
        check("queued accepted", 32'(IN_READY), 32'd0);
        check("queued busy",     32'(BUSY),     32'd1);
        wait_valid(lat);
        check("queued latency", 32'(lat),  32'd2);
        check("queued data",    32'(DATA), 32'h0003);
        drain("queued", 16'h0003);

        // Asynchronous reset in the middle of a build.
        send(5'd9, 4'd0, "rst");
        repeat (4) @(posedge CLK);
        #3 RESET = 1'b1;
        #1;
        check("rst async data",      32'(DATA),      32'd0);
        check("rst async out_valid", 32'(OUT_VALID), 32'd0);
        check("rst async busy",      32'(BUSY),      32'd0);
        check("rst async in_ready",  32'(IN_READY),  32'd1);
        check("rst async err",       32'(ERR),       32'd0);
        @(posedge CLK);
        #1 RESET = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(posedge CLK);
            #1;
            check("rst no stale valid", 32'(OUT_VALID), 32'd0);
        end
        send(5'd3, 4'd5, "post_rst");
        wait_valid(lat);
        check("post_rst latency", 32'(lat),  32'd3);
        check("post_rst data",    32'(DATA), 32'h00E0);
        check("post_rst err",     32'(ERR),  32'd0);
        drain("post_rst", 16'h00E0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
